// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions: instruction/address widths, NOP encoding and the
// fetch queue entry layout.
package fetch_unit_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] NOP_ENC = 32'hC800_0000;

    typedef logic [XLEN-1:0] addr_t;
    typedef logic [ILEN-1:0] instr_t;

    typedef struct packed {
        instr_t instr;
        addr_t  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Instruction queue: circular buffer of {instruction, pc} entries with
// push/pop/flush and occupancy outputs. DEPTH must be a power of two.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic                   push,
    input  fetch_entry_t           push_entry,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_entry_t  storage [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          pop_ok;
    logic          push_ok;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign count   = cnt;
    assign head    = storage[rd_ptr];
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // Pointer and occupancy tracking; flush discards everything at once.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage; contents are only observed while the entry is occupied.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) storage[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues single-outstanding memory reads, buffers
// responses in fetch_queue and presents the head entry to decode.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (sticky misaligned-redirect error).
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
    parameter int              QUEUE_DEPTH = 2,
    parameter logic [ILEN-1:0] NOP_INSTR   = NOP_ENC
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            clk_en,
    output logic            instruction_memory_en,
    output logic [XLEN-1:0] instruction_memory_a,
    input  logic [ILEN-1:0] instruction_memory_v,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [ILEN-1:0] fetch_instr,
    output logic [XLEN-1:0] fetch_pc,
    output logic            fetch_error
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(QUEUE_DEPTH);

    addr_t        pc;
    addr_t        in_flight_pc;
    logic         in_flight;
    logic         err;
    addr_t        redirect_target;
    logic         flush;
    logic         q_push;
    logic         q_pop;
    logic         q_empty;
    logic         q_full;
    logic [CW-1:0] q_count;
    logic [CW:0]  slots_used;
    logic         can_issue;
    logic         issue;
    fetch_entry_t q_head;
    fetch_entry_t q_in;

    // Redirects only act on enabled cycles; a response that was already
    // requested is captured even when clk_en drops.
    assign flush  = clk_en & redirect_valid;
    assign q_pop  = clk_en & ~q_empty & fetch_ready;
    assign q_push = in_flight & ~flush;
    assign q_in   = {instruction_memory_v, in_flight_pc};

    // A same-cycle pop frees a slot, which is what allows back-to-back issue.
    assign slots_used = {1'b0, q_count} + {{CW{1'b0}}, in_flight};
    assign can_issue  = q_pop | (~q_full & (slots_used < DEPTH_W));
    assign issue      = nreset & clk_en & ~halt & ~redirect_valid & ~err & can_issue;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redirect_target = redirect_pc;

    // Sticky error on a misaligned redirect; blocks all further issue.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            err <= 1'b0;
        else if (flush && (redirect_pc[1:0] != 2'b00))
            err <= 1'b1;
    end
`else
    assign redirect_target = redirect_pc & ~32'h3;
    assign err             = 1'b0;
`endif

    // Program counter and single outstanding request tracking.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pc           <= RESET_PC;
            in_flight    <= 1'b0;
            in_flight_pc <= RESET_PC;
        end else begin
            in_flight <= issue;
            if (flush) begin
                pc <= redirect_target;
            end else if (issue) begin
                pc           <= pc + 32'd4;
                in_flight_pc <= pc;
            end
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .nreset     (nreset),
        .push       (q_push),
        .push_entry (q_in),
        .pop        (q_pop),
        .flush      (flush),
        .head       (q_head),
        .empty      (q_empty),
        .full       (q_full),
        .count      (q_count)
    );

    assign instruction_memory_en = issue;
    assign instruction_memory_a  = pc;
    assign fetch_valid           = ~q_empty;
    assign fetch_instr           = q_empty ? NOP_INSTR : q_head.instr;
    assign fetch_pc              = q_empty ? pc : q_head.pc;
    assign fetch_error           = err;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios then random traffic, checked
// against a queue-based reference model of the fetch rules.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int          QD  = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk;
    logic        nreset;
    logic        clk_en;
    logic        instruction_memory_en;
    logic [31:0] instruction_memory_a;
    logic [31:0] instruction_memory_v;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        fetch_error;

    int checks = 0;
    int errors = 0;

    fetch_entry_t mq[$];
    logic [31:0]  m_pc;
    logic [31:0]  m_ifpc;
    bit           m_inf;
    bit           m_err;

    fetch_unit #(
        .RESET_PC    (RPC),
        .QUEUE_DEPTH (QD),
        .NOP_INSTR   (NOP_ENC)
    ) dut (
        .clk                   (clk),
        .nreset                (nreset),
        .clk_en                (clk_en),
        .instruction_memory_en (instruction_memory_en),
        .instruction_memory_a  (instruction_memory_a),
        .instruction_memory_v  (instruction_memory_v),
        .redirect_valid        (redirect_valid),
        .redirect_pc           (redirect_pc),
        .halt                  (halt),
        .fetch_valid           (fetch_valid),
        .fetch_ready           (fetch_ready),
        .fetch_instr           (fetch_instr),
        .fetch_pc              (fetch_pc),
        .fetch_error           (fetch_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1111_1111;
    endfunction

    task automatic chk1(input string tag, input logic got, input bit exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0b expected %0b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc   = RPC;
        m_ifpc = RPC;
        m_inf  = 0;
        m_err  = 0;
    endtask

    task automatic check_reset_outputs();
        chk1 ("rst_en",    instruction_memory_en, 1'b0);
        chk32("rst_addr",  instruction_memory_a,  RPC);
        chk1 ("rst_valid", fetch_valid,           1'b0);
        chk32("rst_instr", fetch_instr,           NOP_ENC);
        chk32("rst_pc",    fetch_pc,              RPC);
        chk1 ("rst_error", fetch_error,           1'b0);
    endtask

    // One cycle: drive inputs just after an edge, check at the falling edge,
    // advance the model at the rising edge, then present the memory response.
    task automatic step(input bit ce, input bit rdy, input bit hlt, input bit rv,
                        input logic [31:0] rpc);
        bit           pop;
        bit           iss;
        bit           fl;
        bit           en_s;
        int           used;
        logic [31:0]  a_s;
        fetch_entry_t e;
        clk_en         = ce;
        fetch_ready    = rdy;
        halt           = hlt;
        redirect_valid = rv;
        redirect_pc    = rpc;
        fl   = ce && rv;
        pop  = ce && rdy && (mq.size() > 0);
        used = mq.size() - int'(pop) + int'(m_inf);
        iss  = ce && !hlt && !rv && !m_err && (used < QD);
        @(negedge clk);
        chk1 ("valid", fetch_valid, mq.size() > 0);
        chk32("instr", fetch_instr, (mq.size() > 0) ? mq[0].instr : NOP_ENC);
        chk32("fpc",   fetch_pc,    (mq.size() > 0) ? mq[0].pc : m_pc);
        chk1 ("en",    instruction_memory_en, iss);
        if (iss) chk32("addr", instruction_memory_a, m_pc);
        chk1 ("error", fetch_error, m_err);
        en_s = instruction_memory_en;
        a_s  = instruction_memory_a;
        @(posedge clk);
        if (fl) begin
            mq.delete();
            m_inf = 0;
`ifdef FETCH_ALIGN_CHECK_EN
            m_pc = rpc;
            if (rpc[1:0] != 2'b00) m_err = 1;
`else
            m_pc = rpc & ~32'h3;
`endif
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_inf) begin
                e.instr = mem_word(m_ifpc);
                e.pc    = m_ifpc;
                mq.push_back(e);
            end
            m_inf = iss;
            if (iss) begin
                m_ifpc = m_pc;
                m_pc   = m_pc + 32'd4;
            end
        end
        #1;
        instruction_memory_v = en_s ? mem_word(a_s) : $urandom();
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        nreset = 1'b1;
        instruction_memory_v = $urandom();
    endtask

    task automatic random_steps(input int n);
        logic [31:0] rpc;
        for (int i = 0; i < n; i++) begin
            rpc = $urandom();
`ifdef FETCH_ALIGN_CHECK_EN
            rpc = rpc & ~32'h3;
`else
            if ($urandom_range(0, 3) != 0) rpc = rpc & ~32'h3;
`endif
            step($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, rpc);
        end
    endtask

    initial begin
        nreset               = 1'b0;
        clk_en               = 1'b1;
        fetch_ready          = 1'b1;
        halt                 = 1'b0;
        redirect_valid       = 1'b0;
        redirect_pc          = '0;
        instruction_memory_v = '0;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        nreset = 1'b1;
        instruction_memory_v = $urandom();

        // Streaming from reset: first request, then one instruction per cycle
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0, '0);

        // Decode stalls: queue fills, issue stops, then drains in order
        model_reset();
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, '0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, '0);

        // Redirect while a request is outstanding
        step(1, 1, 0, 1, 32'h0000_0100);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, '0);

        // Halt with a request outstanding, then resume
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0, '0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, '0);

        // Clock enable low straight after an issue
        step(0, 1, 0, 0, '0);
        step(0, 1, 0, 1, 32'h0000_0200);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, '0);

        // Redirect coinciding with a pop, and with halt
        step(1, 1, 1, 1, 32'h0000_0300);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, '0);

        // Redirect with a misaligned target
        step(1, 1, 0, 1, 32'h0000_0102);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, '0);

        random_steps(400);

        // Reset in the middle of traffic
        for (int i = 0; i < 2; i++) step(1, 0, 0, 0, '0);
        do_reset();
        step(1, 1, 0, 0, '0);
        random_steps(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, first fetch address after reset.
REQ-002 SHALL have parameter QUEUE_DEPTH, default 2, instruction queue entries; power of two, >= 2.
REQ-003 SHALL have parameter NOP_INSTR, default 32'hC8000000, instruction word presented when no valid instruction is available.
REQ-004 SHALL have port clk  in  1  core clock; all state updates on the rising edge.
REQ-005 SHALL have port nreset  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port clk_en  in  1  clock enable; when low, all state holds.
REQ-007 SHALL have port instruction_memory_en  out  1  instruction memory read request.
REQ-008 SHALL have port instruction_memory_a  out  32  byte address of the read request.
REQ-009 SHALL have port instruction_memory_v  in  32  read data, valid exactly one cycle after the request.
REQ-010 SHALL have port redirect_valid  in  1  control-flow redirect from execute.
REQ-011 SHALL have port redirect_pc  in  32  redirect target address.
REQ-012 SHALL have port halt  in  1  stop issuing new fetches.
REQ-013 SHALL have port fetch_valid  out  1  head-of-queue instruction is valid.
REQ-014 SHALL have port fetch_ready  in  1  decode accepts the head entry.
REQ-015 SHALL have port fetch_instr  out  32  head instruction word.
REQ-016 SHALL have port fetch_pc  out  32  address of fetch_instr.
REQ-017 SHALL have port fetch_error  out  1  sticky misalignment error (see Configuration).

Function
REQ-018 SHALL issue a request (instruction_memory_en=1, instruction_memory_a=pc) when clk_en=1, halt=0, redirect_valid=0 and occupancy+in_flight < QUEUE_DEPTH; pc SHALL then advance by 4, wrapping modulo 2^32.
REQ-019 SHALL allow at most one request in flight; the response SHALL be written to the queue tail, with its pc, in the cycle after issue.
REQ-020 SHALL pop the head when fetch_valid=1 and fetch_ready=1; pop and push in the same cycle SHALL leave occupancy unchanged.
REQ-021 SHALL drive fetch_valid=1 iff the queue is non-empty; with the queue empty, fetch_instr=NOP_INSTR and fetch_pc=pc.
REQ-022 SHALL sustain one instruction per cycle with fetch_ready held high and no redirect, after a 2-cycle initial latency (issue, then response).
REQ-023 On redirect_valid=1: queue flushed, any in-flight response discarded, pc <= redirect_pc, no issue that cycle; issuing resumes the next cycle from redirect_pc.
REQ-024 Redirect coinciding with a pop, a push or halt SHALL take priority; the flush SHALL occur and the popped entry is consumed by decode.
REQ-025 halt=1 SHALL block new issues only; the in-flight response SHALL still be queued and the queue SHALL still drain.
REQ-026 clk_en=0 SHALL force instruction_memory_en=0 and freeze pc, queue and in-flight tracking; a request issued in the prior cycle SHALL still be captured.
REQ-027 Full queue: no issue; empty queue with fetch_ready=1: no pop, no underflow.

Reset
REQ-028 nreset low SHALL immediately set pc=RESET_PC, queue empty, in_flight=0, instruction_memory_en=0, instruction_memory_a=RESET_PC, fetch_valid=0, fetch_instr=NOP_INSTR, fetch_pc=RESET_PC, fetch_error=0.
REQ-029 Reset mid-operation SHALL discard all queued and in-flight instructions; first issue SHALL occur on the first enabled edge after release.

Configuration
REQ-030 Macro FETCH_ALIGN_CHECK_EN defined: a redirect with redirect_pc[1:0]!=0 SHALL set fetch_error (sticky until reset) and stop all issuing; the queue is flushed.
REQ-031 Macro FETCH_ALIGN_CHECK_EN undefined: redirect_pc[1:0] SHALL be forced to 0, and fetch_error SHALL be tied 0.

Structure
REQ-032 NOP encoding, instruction width (32) and address width (32) SHALL live in the shared CPU package.
REQ-033 The queue SHALL be a sub-module fetch_queue (storage for instruction plus pc, push/pop/flush, full/empty).

Verification
REQ-034 Reset release, RESET_PC=0, fetch_ready=1, memory word at 0x0 = 0x11111111 -> en high on the first edge with a=0x0, fetch_valid on the second with fetch_instr=0x11111111, fetch_pc=0x0.
REQ-035 Streaming 0x0..0x1C with fetch_ready=1 -> 8 consecutive valid cycles, fetch_pc stepping by 4, no bubbles.
REQ-036 fetch_ready=0 for 5 cycles -> exactly 2 entries queued, en low while full, pc stops at 0x8; on release 0x0 and 0x4 delivered in order.
REQ-037 redirect_valid pulse to 0x100 with a request in flight -> stale response dropped; next fetch_pc=0x100.
REQ-038 halt=1 with 1 in flight -> that entry delivered, then en stays 0 and fetch_valid falls once drained.
REQ-039 FETCH_ALIGN_CHECK_EN defined, redirect to 0x102 -> fetch_error=1 next cycle, en stays 0 until reset.
